ram_port_arbiter: RTL and testbench
===================================

Name: ram_port_arbiter

Overview:
- Shares one RAM_mem port (en/we/addr/data) between two requesters: requester 0 (core data interface) and requester 1 (loader/DMA/debug master).
- Grants are combinational in the request cycle. The RAM read is combinational, so the access completes in the grant cycle.
- Response (rvalid, rdata) is registered and returned exactly one cycle after the grant.
- Supports round-robin or fixed priority, and a bounded lock for back-to-back bursts.

Parameters:
- ADDR_WIDTH, 20, byte-address width; equals $clog2 of the RAM MEM_WIDTH (1048576).
- FIXED_PRIO, 0, 0 = round-robin; 1 = requester 0 always wins ties.
- MAX_HOLD, 4, maximum consecutive grants to one locked requester while the other is requesting; range 1..15.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- req0_i / req1_i  in  1  access request, held until granted.
- we0_i / we1_i  in  4  byte write enables; 0000 = read.
- addr0_i / addr1_i  in  ADDR_WIDTH  byte address.
- wdata0_i / wdata1_i  in  32  write data.
- lock0_i / lock1_i  in  1  keep ownership for the next cycle; sampled only while granted.
- gnt0_o / gnt1_o  out  1  request accepted this cycle; combinational.
- rvalid0_o / rvalid1_o  out  1  one-cycle response pulse, one cycle after the grant.
- rdata0_o / rdata1_o  out  32  read data, valid with rvalid; 0 for writes.
- mem_en_o  out  1  RAM port enable.
- mem_we_o  out  4  RAM byte write enables.
- mem_addr_o  out  ADDR_WIDTH  RAM address.
- mem_wdata_o  out  32  RAM write data.
- mem_rdata_i  in  32  RAM combinational read data.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - state=IDLE, rr_ptr=0 (requester 0 favoured), hold_cnt=0.
  - rvalid0_o/1_o=0, rdata0_o/1_o=0.
  - Any in-flight response is dropped; no rvalid is emitted for it after reset release.
- States:
  - IDLE: no owner.
  - OWN0: requester 0 holds the lock.
  - OWN1: requester 1 holds the lock.
- Grant rules, per cycle, combinational:
  - OWNx with reqx_i=1 and (hold_cnt<MAX_HOLD or other req=0): gntx=1.
  - OWNx with reqx_i=0: lock is released; arbitrate as IDLE in the same cycle.
  - OWNx with hold_cnt==MAX_HOLD and other req=1: the other requester is granted; state returns to IDLE, or to the other's OWN if it asserts lock.
  - IDLE, single request: that requester is granted.
  - IDLE, both requesting: FIXED_PRIO=1 grants requester 0; otherwise grant requester rr_ptr.
  - At most one of gnt0_o/gnt1_o is high in any cycle.
- On a grant:
  - mem_* is driven from the granted requester's inputs.
  - Next state is OWNx if lockx_i=1, else IDLE.
  - rr_ptr <= granted index XOR 1.
  - hold_cnt increments while the same owner is re-granted, and clears on an owner change or on IDLE.
  - hold_cnt saturates at MAX_HOLD.
- No grant: mem_en_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0.
- Response:
  - On the posedge ending a grant cycle, rvalidx_o<=1.
  - rdatax_o <= mem_rdata_i when mem_we_o==0, else 0.
  - The next cycle: rvalid drops unless re-granted.
  - A back-to-back grant produces a continuous rvalid stream, one pulse per grant, in grant order.
- Writes are committed by the RAM at the posedge of the grant cycle.
  - A read granted in the following cycle returns the new data.
- Addresses and we patterns pass through unchanged; alignment is the requester's responsibility.
- lockx_i is ignored while requester x is not granted.
- A locked owner dropping req frees the port immediately; there are no idle bubbles.

Test Plan:
- Single read: RAM[0x100..0x103]=DE AD BE EF; req0=1, we0=0000, addr0=0x100 -> gnt0=1 same cycle; next cycle rvalid0=1, rdata0=0xEFBEADDE; gnt1=0, rvalid1=0 throughout.
- Write then read: req1 we1=1111, addr1=0x200, wdata1=0x12345678, then the same address read next cycle -> rvalid1 twice; second rdata1=0x12345678; first rdata1=0.
- Simultaneous round-robin: after reset, req0=req1=1 continuously with no lock, 6 cycles -> grants 0,1,0,1,0,1; rvalid follows one cycle later with matching rdata.
- Lock bound: MAX_HOLD=4; req0+lock0 held, req1 held -> gnt0 for 4 cycles, then gnt1 for 1 cycle, then requester 0 resumes.
- Fixed priority: FIXED_PRIO=1, both requesting with no lock -> gnt0 every cycle; gnt1 only when req0=0.
- Reset mid-operation: reset_n=0 asynchronously in the cycle after a grant -> rvalid0=0 immediately, no pulse after release; first post-reset tie goes to requester 0.

Source files
------------

// File: rtl/ram_port_arbiter.sv
// Two-requester arbiter sharing one combinational-read RAM port, with round-robin or
// fixed priority, a bounded ownership lock and a registered one-cycle-later response.
module ram_port_arbiter #(
    parameter int ADDR_WIDTH = 20,
    parameter int FIXED_PRIO = 0,
    parameter int MAX_HOLD   = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,

    input  logic                  req0_i,
    input  logic [3:0]            we0_i,
    input  logic [ADDR_WIDTH-1:0] addr0_i,
    input  logic [31:0]           wdata0_i,
    input  logic                  lock0_i,
    output logic                  gnt0_o,
    output logic                  rvalid0_o,
    output logic [31:0]           rdata0_o,

    input  logic                  req1_i,
    input  logic [3:0]            we1_i,
    input  logic [ADDR_WIDTH-1:0] addr1_i,
    input  logic [31:0]           wdata1_i,
    input  logic                  lock1_i,
    output logic                  gnt1_o,
    output logic                  rvalid1_o,
    output logic [31:0]           rdata1_o,

    output logic                  mem_en_o,
    output logic [3:0]            mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [31:0]           mem_wdata_o,
    input  logic [31:0]           mem_rdata_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    localparam logic [3:0] HOLD_LIMIT = 4'(MAX_HOLD);

    state_t     state;
    logic       rr_ptr;
    logic [3:0] hold_cnt;
    logic [3:0] hold_inc;

    // hold_cnt counts consecutive grants to the current owner, saturating at the bound.
    assign hold_inc = (hold_cnt == HOLD_LIMIT) ? hold_cnt : hold_cnt + 4'd1;

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        gnt0_o      = 1'b0;
        gnt1_o      = 1'b0;
        mem_we_o    = '0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;

        if (state == OWN0 && req0_i) begin
            if (hold_cnt < HOLD_LIMIT || !req1_i) gnt0_o = 1'b1;
            else                                  gnt1_o = 1'b1;
        end else if (state == OWN1 && req1_i) begin
            if (hold_cnt < HOLD_LIMIT || !req0_i) gnt1_o = 1'b1;
            else                                  gnt0_o = 1'b1;
        end else if (req0_i && req1_i) begin
            // A released lock falls through to plain arbitration in the same cycle.
            if (FIXED_PRIO != 0 || !rr_ptr) gnt0_o = 1'b1;
            else                            gnt1_o = 1'b1;
        end else begin
            gnt0_o = req0_i;
            gnt1_o = req1_i;
        end

        if (gnt0_o) begin
            mem_we_o    = we0_i;
            mem_addr_o  = addr0_i;
            mem_wdata_o = wdata0_i;
        end else if (gnt1_o) begin
            mem_we_o    = we1_i;
            mem_addr_o  = addr1_i;
            mem_wdata_o = wdata1_i;
        end
    end

    assign mem_en_o = gnt0_o | gnt1_o;

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values of the others.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            rr_ptr    <= 1'b0;
            hold_cnt  <= '0;
            rvalid0_o <= 1'b0;
            rvalid1_o <= 1'b0;
            rdata0_o  <= '0;
            rdata1_o  <= '0;
        end else begin
            rvalid0_o <= gnt0_o;
            rvalid1_o <= gnt1_o;
            rdata0_o  <= (gnt0_o && mem_we_o == 4'b0000) ? mem_rdata_i : '0;
            rdata1_o  <= (gnt1_o && mem_we_o == 4'b0000) ? mem_rdata_i : '0;

            if (gnt0_o) begin
                rr_ptr <= 1'b1;
                if (lock0_i) begin
                    state    <= OWN0;
                    hold_cnt <= (state == OWN0) ? hold_inc : 4'd1;
                end else begin
                    state    <= IDLE;
                    hold_cnt <= '0;
                end
            end else if (gnt1_o) begin
                rr_ptr <= 1'b0;
                if (lock1_i) begin
                    state    <= OWN1;
                    hold_cnt <= (state == OWN1) ? hold_inc : 4'd1;
                end else begin
                    state    <= IDLE;
                    hold_cnt <= '0;
                end
            end else begin
                state    <= IDLE;
                hold_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: a round-robin and a fixed-priority instance share stimulus,
// each with its own byte RAM and an owner/streak reference model checked every cycle.
module tb_ram_port_arbiter;

    localparam int AW       = 20;
    localparam int MAX_HOLD = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_n = 1'b0;
    logic          req0 = 1'b0, req1 = 1'b0, lock0 = 1'b0, lock1 = 1'b0;
    logic [3:0]    we0 = '0, we1 = '0;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic [31:0]   wdata0 = '0, wdata1 = '0;

    logic [1:0]    gnt0, gnt1, rv0, rv1, mem_en;
    logic [31:0]   rd0 [2];
    logic [31:0]   rd1 [2];
    logic [3:0]    mem_we [2];
    logic [AW-1:0] mem_addr [2];
    logic [31:0]   mem_wdata [2];
    logic [31:0]   mem_rdata [2];

    int n_checks = 0;
    int n_fail   = 0;

    ram_port_arbiter #(.ADDR_WIDTH(AW), .FIXED_PRIO(0), .MAX_HOLD(MAX_HOLD)) dut_rr (
        .clk(clk), .reset_n(reset_n),
        .req0_i(req0), .we0_i(we0), .addr0_i(addr0), .wdata0_i(wdata0), .lock0_i(lock0),
        .gnt0_o(gnt0[0]), .rvalid0_o(rv0[0]), .rdata0_o(rd0[0]),
        .req1_i(req1), .we1_i(we1), .addr1_i(addr1), .wdata1_i(wdata1), .lock1_i(lock1),
        .gnt1_o(gnt1[0]), .rvalid1_o(rv1[0]), .rdata1_o(rd1[0]),
        .mem_en_o(mem_en[0]), .mem_we_o(mem_we[0]), .mem_addr_o(mem_addr[0]),
        .mem_wdata_o(mem_wdata[0]), .mem_rdata_i(mem_rdata[0])
    );

    ram_port_arbiter #(.ADDR_WIDTH(AW), .FIXED_PRIO(1), .MAX_HOLD(MAX_HOLD)) dut_fp (
        .clk(clk), .reset_n(reset_n),
        .req0_i(req0), .we0_i(we0), .addr0_i(addr0), .wdata0_i(wdata0), .lock0_i(lock0),
        .gnt0_o(gnt0[1]), .rvalid0_o(rv0[1]), .rdata0_o(rd0[1]),
        .req1_i(req1), .we1_i(we1), .addr1_i(addr1), .wdata1_i(wdata1), .lock1_i(lock1),
        .gnt1_o(gnt1[1]), .rvalid1_o(rv1[1]), .rdata1_o(rd1[1]),
        .mem_en_o(mem_en[1]), .mem_we_o(mem_we[1]), .mem_addr_o(mem_addr[1]),
        .mem_wdata_o(mem_wdata[1]), .mem_rdata_i(mem_rdata[1])
    );

    // Behavioural RAM per instance: 4 KiB of bytes, low 12 address bits, little-endian,
    // combinational read, byte-enabled write at the clock edge, cleared by reset.
    for (genvar gi = 0; gi < 2; gi++) begin : g_ram
        logic [7:0]  ram [4096];
        logic [11:0] a;
        assign a = mem_addr[gi][11:0];
        assign mem_rdata[gi] = {ram[a + 12'd3], ram[a + 12'd2], ram[a + 12'd1], ram[a]};
        always @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                for (int k = 0; k < 4096; k++) ram[k] <= '0;
            end else if (mem_en[gi]) begin
                for (int k = 0; k < 4; k++)
                    if (mem_we[gi][k]) ram[a + 12'(k)] <= mem_wdata[gi][8*k +: 8];
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: who owns the port, how long its streak is, and whose turn a tie is.
    int          owner   [2];
    int          streak  [2];
    int          turn    [2];
    int          last_g  [2];
    logic        exp_rv  [2][2];
    logic [31:0] exp_rd  [2][2];
    logic [7:0]  mm      [2][4096];

    function automatic int pick(input int i);
        if (owner[i] == 0 && req0) return (streak[i] < MAX_HOLD || !req1) ? 0 : 1;
        if (owner[i] == 1 && req1) return (streak[i] < MAX_HOLD || !req0) ? 1 : 0;
        if (req0 && req1) return (i == 1) ? 0 : turn[i];
        if (req0) return 0;
        if (req1) return 1;
        return -1;
    endfunction

    task automatic compare_one(input int i);
        string       tag;
        int          g;
        logic [3:0]  ewe;
        logic [19:0] ea;
        logic [31:0] ed;
        logic [11:0] b;
        logic        lk;
        tag = (i == 0) ? "rr" : "fp";
        if (!reset_n) begin
            check({tag, " rvalid0 in reset"}, 32'(rv0[i]), 32'd0);
            check({tag, " rvalid1 in reset"}, 32'(rv1[i]), 32'd0);
            check({tag, " rdata0 in reset"}, rd0[i], 32'd0);
            check({tag, " rdata1 in reset"}, rd1[i], 32'd0);
            owner[i] = -1; streak[i] = 0; turn[i] = 0; last_g[i] = -1;
            for (int k = 0; k < 2; k++) begin exp_rv[i][k] = 1'b0; exp_rd[i][k] = '0; end
            for (int k = 0; k < 4096; k++) mm[i][k] = '0;
            return;
        end
        g   = pick(i);
        ewe = (g == 0) ? we0    : (g == 1) ? we1    : 4'd0;
        ea  = (g == 0) ? addr0  : (g == 1) ? addr1  : 20'd0;
        ed  = (g == 0) ? wdata0 : (g == 1) ? wdata1 : 32'd0;
        check({tag, " gnt0"}, 32'(gnt0[i]), 32'(g == 0));
        check({tag, " gnt1"}, 32'(gnt1[i]), 32'(g == 1));
        check({tag, " mem_en"}, 32'(mem_en[i]), 32'(g >= 0));
        check({tag, " mem_we"}, 32'(mem_we[i]), 32'(ewe));
        check({tag, " mem_addr"}, 32'(mem_addr[i]), 32'(ea));
        check({tag, " mem_wdata"}, mem_wdata[i], ed);
        check({tag, " rvalid0"}, 32'(rv0[i]), 32'(exp_rv[i][0]));
        check({tag, " rvalid1"}, 32'(rv1[i]), 32'(exp_rv[i][1]));
        if (exp_rv[i][0]) check({tag, " rdata0"}, rd0[i], exp_rd[i][0]);
        if (exp_rv[i][1]) check({tag, " rdata1"}, rd1[i], exp_rd[i][1]);

        for (int k = 0; k < 2; k++) exp_rv[i][k] = (g == k);
        last_g[i] = g;
        if (g < 0) begin
            owner[i] = -1; streak[i] = 0;
            return;
        end
        b = ea[11:0];
        exp_rd[i][g] = (ewe == 4'd0) ?
            {mm[i][b + 12'd3], mm[i][b + 12'd2], mm[i][b + 12'd1], mm[i][b]} : 32'd0;
        for (int k = 0; k < 4; k++)
            if (ewe[k]) mm[i][b + 12'(k)] = ed[8*k +: 8];
        lk = (g == 0) ? lock0 : lock1;
        if (lk) begin
            streak[i] = (owner[i] == g) ? ((streak[i] < MAX_HOLD) ? streak[i] + 1 : MAX_HOLD) : 1;
            owner[i]  = g;
        end else begin
            owner[i]  = -1;
            streak[i] = 0;
        end
        turn[i] = g ^ 1;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) compare_one(i);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        check("reset rvalid0", 32'(rv0[0]), 32'd0);
        check("reset rdata0", rd0[0], 32'd0);
        check("reset mem_en", 32'(mem_en[0]), 32'd0);

        // Load DE AD BE EF at 0x100, then read it back as one word.
        step(); req0 = 1'b1; we0 = 4'hF; addr0 = 20'h00100; wdata0 = 32'hEFBEADDE;
        @(negedge clk);
        check("preload gnt0", 32'(gnt0[0]), 32'd1);
        step(); we0 = 4'h0;
        @(negedge clk);
        check("single read gnt0", 32'(gnt0[0]), 32'd1);
        check("single read gnt1", 32'(gnt1[0]), 32'd0);
        check("preload rdata0", rd0[0], 32'd0);
        step(); req0 = 1'b0;
        @(negedge clk);
        check("single read rvalid0", 32'(rv0[0]), 32'd1);
        check("single read rdata0", rd0[0], 32'hEFBEADDE);
        check("single read rvalid1", 32'(rv1[0]), 32'd0);

        // Write then read on requester 1.
        step(); req1 = 1'b1; we1 = 4'hF; addr1 = 20'h00200; wdata1 = 32'h12345678;
        @(negedge clk);
        check("write gnt1", 32'(gnt1[0]), 32'd1);
        check("fp gnt1 when req0 idle", 32'(gnt1[1]), 32'd1);
        step(); we1 = 4'h0;
        @(negedge clk);
        check("write rvalid1", 32'(rv1[0]), 32'd1);
        check("write rdata1", rd1[0], 32'd0);
        step(); req1 = 1'b0;
        @(negedge clk);
        check("readback rvalid1", 32'(rv1[0]), 32'd1);
        check("readback rdata1", rd1[0], 32'h12345678);

        // Grant to 0 leaves the tie pointer on 1; reset must drop the response and the pointer.
        step(); req0 = 1'b1; addr0 = 20'h00100;
        @(negedge clk);
        check("pre-reset gnt0", 32'(gnt0[0]), 32'd1);
        @(posedge clk);
        #1 check("pre-reset rvalid0", 32'(rv0[0]), 32'd1);
        req0 = 1'b0;
        #1 reset_n = 1'b0;
        #1 check("async reset rvalid0", 32'(rv0[0]), 32'd0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        check("no pulse after release", 32'(rv0[0]), 32'd0);

        // Continuous tie without lock alternates 0,1,0,1,0,1; fixed priority always picks 0.
        step(); req0 = 1'b1; req1 = 1'b1; we0 = '0; we1 = '0;
        addr0 = 20'h00100; addr1 = 20'h00200;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check($sformatf("rr gnt0 cycle %0d", c), 32'(gnt0[0]), 32'((c % 2) == 0));
            check($sformatf("rr gnt1 cycle %0d", c), 32'(gnt1[0]), 32'((c % 2) == 1));
            check($sformatf("fp gnt0 cycle %0d", c), 32'(gnt0[1]), 32'd1);
            step();
        end

        // Locked requester 0 gets four grants, then requester 1 gets one.
        lock0 = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check($sformatf("lock gnt0 cycle %0d", c), 32'(gnt0[0]), 32'(c != 4));
            step();
        end
        req0 = 1'b0; req1 = 1'b0; lock0 = 1'b0;

        // Random traffic; a pending request keeps its fields until granted.
        for (int n = 0; n < 3000; n++) begin
            step();
            if (n == 1500) begin
                req0 = 1'b0; req1 = 1'b0; reset_n = 1'b0;
                step(); step();
                reset_n = 1'b1;
            end
            if (!req0 || last_g[0] == 0) begin
                req0   = ($urandom_range(0, 3) != 0);
                we0    = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
                addr0  = AW'($urandom) & 20'hF003F;
                wdata0 = $urandom;
            end
            if (!req1 || last_g[0] == 1) begin
                req1   = ($urandom_range(0, 3) != 0);
                we1    = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
                addr1  = AW'($urandom) & 20'hF003F;
                wdata1 = $urandom;
            end
            lock0 = ($urandom_range(0, 2) != 0);
            lock1 = ($urandom_range(0, 2) != 0);
        end
        req0 = 1'b0; req1 = 1'b0;
        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
